// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: branch condition codes,
// sequencer states and the flush counter width.
package pc_seq_pkg;

    localparam logic [2:0] COND_BEQ    = 3'b000;
    localparam logic [2:0] COND_BNE    = 3'b001;
    localparam logic [2:0] COND_BLTZ   = 3'b010;
    localparam logic [2:0] COND_BGEZ   = 3'b011;
    localparam logic [2:0] COND_BLEZ   = 3'b100;
    localparam logic [2:0] COND_BGTZ   = 3'b101;
    localparam logic [2:0] COND_ALWAYS = 3'b110;
    localparam logic [2:0] COND_NEVER  = 3'b111;

    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_SLOT
    } state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluator: maps a condition code and the ALU
// zero/neg flags to a single take bit.
module br_cond_eval
    import pc_seq_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       zero,
    input  logic       neg,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_BEQ:    take = zero;
            COND_BNE:    take = ~zero;
            COND_BLTZ:   take = neg;
            COND_BGEZ:   take = ~neg;
            COND_BLEZ:   take = neg | zero;
            COND_BGTZ:   take = ~(neg | zero);
            COND_ALWAYS: take = 1'b1;
            COND_NEVER:  take = 1'b0;
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with jr > jmp > branch redirect priority, post-redirect
// flush bubbles, and an optional architectural delay slot.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 1,
    parameter int                DELAY_SLOT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              jr_valid_i,
    input  logic [ADDR_W-1:0] jr_addr_i,
    input  logic              jmp_valid_i,
    input  logic [25:0]       jmp_index_i,
    input  logic              br_valid_i,
    input  logic [2:0]        br_cond_i,
    input  logic [15:0]       br_offset_i,
    input  logic              zero_i,
    input  logic              neg_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] link_addr_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic              align_err_o
);

    localparam logic [ADDR_W-1:0] LINK_OFS = (DELAY_SLOT != 0) ? ADDR_W'(8) : ADDR_W'(4);

    state_t                 state, state_n;
    logic [FLUSH_CNT_W-1:0] cnt, cnt_n;
    logic [ADDR_W-1:0]      tgt, tgt_n;
    logic [ADDR_W-1:0]      pc_n;
    logic                   flush_n;

    logic [ADDR_W-1:0]        p4;
    logic [ADDR_W-1:0]        jmp_tgt;
    logic [ADDR_W-1:0]        br_tgt;
    logic signed [ADDR_W-1:0] br_disp;
    logic [ADDR_W-1:0]        target;
    logic                     br_take;
    logic                     accept;
    logic                     taken;

    br_cond_eval u_cond (
        .cond (br_cond_i),
        .zero (zero_i),
        .neg  (neg_i),
        .take (br_take)
    );

    assign p4 = pc_o + ADDR_W'(4);

    // The region above the 26-bit index only exists when ADDR_W exceeds 28.
    generate
        if (ADDR_W > 28) begin : g_jmp_hi
            assign jmp_tgt = {p4[ADDR_W-1:28], jmp_index_i, 2'b00};
        end else begin : g_jmp_lo
            assign jmp_tgt = {jmp_index_i, 2'b00};
        end
    endgenerate

    assign br_disp = {{(ADDR_W-18){br_offset_i[15]}}, br_offset_i, 2'b00};
    assign br_tgt  = p4 + $unsigned(br_disp);

    assign accept = (state == ST_RUN) && !stall_i;
    assign taken  = accept && (jr_valid_i || jmp_valid_i || (br_valid_i && br_take));

    always_comb begin
        target = br_tgt;
        if (jr_valid_i)       target = {jr_addr_i[ADDR_W-1:2], 2'b00};
        else if (jmp_valid_i) target = jmp_tgt;
    end

    assign redirect_o  = taken;
    assign align_err_o = taken && jr_valid_i && (jr_addr_i[1:0] != 2'b00);
    assign link_addr_o = pc_o + LINK_OFS;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tgt_n   = tgt;
        pc_n    = pc_o;
        flush_n = flush_o;
        if (!stall_i) begin
            case (state)
                ST_RUN: begin
                    flush_n = 1'b0;
                    pc_n    = p4;
                    if (taken) begin
                        if (DELAY_SLOT != 0) begin
                            tgt_n   = target;
                            state_n = ST_SLOT;
                        end else begin
                            pc_n    = target;
                            cnt_n   = FLUSH_CNT_W'(FLUSH_CYCLES);
                            flush_n = 1'b1;
                            state_n = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    pc_n = p4;
                    if (cnt == FLUSH_CNT_W'(1)) begin
                        cnt_n   = '0;
                        flush_n = 1'b0;
                        state_n = ST_RUN;
                    end else begin
                        cnt_n   = cnt - FLUSH_CNT_W'(1);
                        flush_n = 1'b1;
                    end
                end
                ST_SLOT: begin
                    pc_n    = tgt;
                    flush_n = 1'b0;
                    state_n = ST_RUN;
                end
                default: begin
                    state_n = ST_RUN;
                    flush_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            cnt     <= '0;
            tgt     <= '0;
            pc_o    <= RESET_PC;
            flush_o <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            tgt     <= tgt_n;
            pc_o    <= pc_n;
            flush_o <= flush_n;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: three parameterisations share one stimulus
// stream; each step queues the expected outputs of the instance under test.
module tb_pc_sequencer;

    typedef struct {
        int          d;
        logic [31:0] pc;
        logic        fl;
        logic        rd;
        logic        ae;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        jr_valid_i;
    logic [31:0] jr_addr_i;
    logic        jmp_valid_i;
    logic [25:0] jmp_index_i;
    logic        br_valid_i;
    logic [2:0]  br_cond_i;
    logic [15:0] br_offset_i;
    logic        zero_i;
    logic        neg_i;

    logic [31:0] pc_w   [3];
    logic [31:0] link_w [3];
    logic        fl_w   [3];
    logic        rd_w   [3];
    logic        ae_w   [3];

    exp_t  exp_q [$];
    string nm_q  [$];
    int    checks = 0;
    int    errors = 0;

    // {cond, zero, neg, expected take}
    logic [5:0] cond_tbl [16] = '{
        6'b000_10_1, 6'b000_00_0, 6'b001_00_1, 6'b001_10_0,
        6'b010_01_1, 6'b010_00_0, 6'b011_00_1, 6'b011_01_0,
        6'b100_10_1, 6'b100_01_1, 6'b100_00_0, 6'b101_00_1,
        6'b101_10_0, 6'b101_01_0, 6'b110_00_1, 6'b111_11_0
    };

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h400), .FLUSH_CYCLES(1), .DELAY_SLOT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .jr_valid_i(jr_valid_i), .jr_addr_i(jr_addr_i),
        .jmp_valid_i(jmp_valid_i), .jmp_index_i(jmp_index_i),
        .br_valid_i(br_valid_i), .br_cond_i(br_cond_i), .br_offset_i(br_offset_i),
        .zero_i(zero_i), .neg_i(neg_i),
        .pc_o(pc_w[0]), .link_addr_o(link_w[0]), .flush_o(fl_w[0]),
        .redirect_o(rd_w[0]), .align_err_o(ae_w[0])
    );

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h80), .FLUSH_CYCLES(3), .DELAY_SLOT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .jr_valid_i(jr_valid_i), .jr_addr_i(jr_addr_i),
        .jmp_valid_i(jmp_valid_i), .jmp_index_i(jmp_index_i),
        .br_valid_i(br_valid_i), .br_cond_i(br_cond_i), .br_offset_i(br_offset_i),
        .zero_i(zero_i), .neg_i(neg_i),
        .pc_o(pc_w[1]), .link_addr_o(link_w[1]), .flush_o(fl_w[1]),
        .redirect_o(rd_w[1]), .align_err_o(ae_w[1])
    );

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .FLUSH_CYCLES(1), .DELAY_SLOT(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .jr_valid_i(jr_valid_i), .jr_addr_i(jr_addr_i),
        .jmp_valid_i(jmp_valid_i), .jmp_index_i(jmp_index_i),
        .br_valid_i(br_valid_i), .br_cond_i(br_cond_i), .br_offset_i(br_offset_i),
        .zero_i(zero_i), .neg_i(neg_i),
        .pc_o(pc_w[2]), .link_addr_o(link_w[2]), .flush_o(fl_w[2]),
        .redirect_o(rd_w[2]), .align_err_o(ae_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic idle();
        stall_i     = 1'b0;
        jr_valid_i  = 1'b0;
        jr_addr_i   = '0;
        jmp_valid_i = 1'b0;
        jmp_index_i = '0;
        br_valid_i  = 1'b0;
        br_cond_i   = 3'b111;
        br_offset_i = '0;
        zero_i      = 1'b0;
        neg_i       = 1'b0;
    endtask

    task automatic expect_out(input int d, input logic [31:0] pc, input logic fl,
                              input logic rd, input logic ae, input string nm);
        exp_t e;
        e.d = d; e.pc = pc; e.fl = fl; e.rd = rd; e.ae = ae;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        expect_out(0, 32'h400, 0, 0, 0, "rst_a");
        expect_out(1, 32'h80,  0, 0, 0, "rst_b");
        expect_out(2, 32'h0,   0, 0, 0, "rst_c");
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle, compare everything queued for that cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            string       nm;
            logic [31:0] lk;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            lk = e.pc + ((e.d == 2) ? 32'd8 : 32'd4);
            checks++;
            if (pc_w[e.d] !== e.pc || fl_w[e.d] !== e.fl || rd_w[e.d] !== e.rd ||
                ae_w[e.d] !== e.ae || link_w[e.d] !== lk) begin
                errors++;
                $display("FAIL %s dut%0d: got pc=%h fl=%b rd=%b ae=%b link=%h, want pc=%h fl=%b rd=%b ae=%b link=%h",
                         nm, e.d, pc_w[e.d], fl_w[e.d], rd_w[e.d], ae_w[e.d], link_w[e.d],
                         e.pc, e.fl, e.rd, e.ae, lk);
            end
        end
    end

    initial begin
        logic [31:0] pa;
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;

        do_reset();
        expect_out(0, 32'h400, 0, 0, 0, "seq0"); tick();
        expect_out(0, 32'h404, 0, 0, 0, "seq1"); tick();
        expect_out(0, 32'h408, 0, 0, 0, "seq2"); tick();

        // Move A to 0x100, then BEQ +3 words; requests during the bubble are ignored.
        jr_valid_i = 1; jr_addr_i = 32'hFC;
        expect_out(0, 32'h40C, 0, 1, 0, "jr_a"); tick(); idle();
        expect_out(0, 32'hFC, 1, 0, 0, "jr_a_flush"); tick();
        br_valid_i = 1; br_cond_i = 3'b000; zero_i = 1; br_offset_i = 16'h0003;
        expect_out(0, 32'h100, 0, 1, 0, "beq_take"); tick(); idle();
        jr_valid_i = 1; jr_addr_i = 32'h9000;
        expect_out(0, 32'h110, 1, 0, 0, "beq_flush"); tick(); idle();
        expect_out(0, 32'h114, 0, 0, 0, "beq_after"); tick();
        br_valid_i = 1; br_cond_i = 3'b000; zero_i = 0; br_offset_i = 16'h0003;
        expect_out(0, 32'h118, 0, 0, 0, "beq_not"); tick(); idle();

        // Priority: jr beats jmp and branch, then jmp beats branch.
        jr_valid_i = 1; jr_addr_i = 32'h1FC;
        expect_out(0, 32'h11C, 0, 1, 0, "jr_to_200"); tick(); idle();
        expect_out(0, 32'h1FC, 1, 0, 0, "jr_to_200_fl"); tick();
        jr_valid_i = 1; jr_addr_i = 32'h8000; jmp_valid_i = 1; jmp_index_i = 26'h123;
        br_valid_i = 1; br_cond_i = 3'b110; br_offset_i = 16'h0005;
        expect_out(0, 32'h200, 0, 1, 0, "prio_req"); tick(); idle();
        expect_out(0, 32'h8000, 1, 0, 0, "prio_tgt"); tick();
        expect_out(0, 32'h8004, 0, 0, 0, "prio_after"); tick();
        jmp_valid_i = 1; jmp_index_i = 26'h40; br_valid_i = 1; br_cond_i = 3'b110; br_offset_i = 16'h0005;
        expect_out(0, 32'h8008, 0, 1, 0, "jmp_req"); tick(); idle();
        expect_out(0, 32'h100, 1, 0, 0, "jmp_tgt"); tick();

        // Wrap-around and misaligned jr.
        jr_valid_i = 1; jr_addr_i = 32'hFFFF_FFF8;
        expect_out(0, 32'h104, 0, 1, 0, "jr_top"); tick(); idle();
        expect_out(0, 32'hFFFF_FFF8, 1, 0, 0, "jr_top_fl"); tick();
        br_valid_i = 1; br_cond_i = 3'b110; br_offset_i = 16'h0000;
        expect_out(0, 32'hFFFF_FFFC, 0, 1, 0, "wrap_req"); tick(); idle();
        expect_out(0, 32'h0, 1, 0, 0, "wrap_tgt"); tick();
        jr_valid_i = 1; jr_addr_i = 32'h1003;
        expect_out(0, 32'h4, 0, 1, 1, "misalign_req"); tick(); idle();
        expect_out(0, 32'h1000, 1, 0, 0, "misalign_tgt"); tick();
        expect_out(0, 32'h1004, 0, 0, 0, "misalign_after"); tick();
        br_valid_i = 1; br_cond_i = 3'b111; zero_i = 1; neg_i = 1; br_offset_i = 16'h0005;
        expect_out(0, 32'h1008, 0, 0, 0, "never"); tick(); idle();
        expect_out(0, 32'h100C, 0, 0, 0, "never_after"); tick();
        br_valid_i = 1; br_cond_i = 3'b010; neg_i = 1; br_offset_i = 16'hFFFE;
        expect_out(0, 32'h1010, 0, 1, 0, "bltz_back"); tick(); idle();
        expect_out(0, 32'h100C, 1, 0, 0, "bltz_tgt"); tick();

        // Delay slot instance.
        do_reset();
        jr_valid_i = 1; jr_addr_i = 32'h3C;
        expect_out(2, 32'h0, 0, 1, 0, "ds_jr"); tick(); idle();
        expect_out(2, 32'h4, 0, 0, 0, "ds_jr_slot"); tick();
        expect_out(2, 32'h3C, 0, 0, 0, "ds_jr_tgt"); tick();
        jmp_valid_i = 1; jmp_index_i = 26'h100;
        expect_out(2, 32'h40, 0, 1, 0, "ds_jmp"); tick(); idle();
        jr_valid_i = 1; jr_addr_i = 32'h7000; br_valid_i = 1; br_cond_i = 3'b110;
        expect_out(2, 32'h44, 0, 0, 0, "ds_ignore"); tick(); idle();
        expect_out(2, 32'h400, 0, 0, 0, "ds_tgt"); tick();
        expect_out(2, 32'h404, 0, 0, 0, "ds_after"); tick();

        // Three-bubble flush with a stall in the middle, then async reset mid-flush.
        do_reset();
        br_valid_i = 1; br_cond_i = 3'b110; br_offset_i = 16'h0004;
        expect_out(1, 32'h80, 0, 1, 0, "b_br"); tick(); idle();
        expect_out(1, 32'h94, 1, 0, 0, "b_fl1"); tick();
        stall_i = 1; jr_valid_i = 1; jr_addr_i = 32'h5000;
        expect_out(1, 32'h98, 1, 0, 0, "b_stall1"); tick();
        expect_out(1, 32'h98, 1, 0, 0, "b_stall2"); tick(); idle();
        expect_out(1, 32'h98, 1, 0, 0, "b_fl2"); tick();
        expect_out(1, 32'h9C, 1, 0, 0, "b_fl3"); tick();
        expect_out(1, 32'hA0, 0, 0, 0, "b_run"); tick();
        stall_i = 1; jr_valid_i = 1; jr_addr_i = 32'h5000;
        expect_out(1, 32'hA4, 0, 0, 0, "b_stall_run"); tick(); idle();
        br_valid_i = 1; br_cond_i = 3'b110; br_offset_i = 16'h0000;
        expect_out(1, 32'hA4, 0, 1, 0, "b_br2"); tick(); idle();
        expect_out(1, 32'hA8, 1, 0, 0, "b_br2_fl1"); tick();
        rst_n = 1'b0;
        expect_out(1, 32'h80, 0, 0, 0, "b_async_rst");
        expect_out(0, 32'h400, 0, 0, 0, "a_async_rst");
        expect_out(2, 32'h0, 0, 0, 0, "c_async_rst");
        tick();
        rst_n = 1'b1;
        expect_out(1, 32'h80, 0, 0, 0, "b_rst_rel"); tick();
        expect_out(1, 32'h84, 0, 0, 0, "b_rst_run"); tick();

        // Condition-code table on instance A (offset +1 word when taken).
        pa = 32'h408;
        for (int i = 0; i < 16; i++) begin
            logic [5:0] t;
            t = cond_tbl[i];
            br_valid_i = 1; br_cond_i = t[5:3]; zero_i = t[2]; neg_i = t[1]; br_offset_i = 16'h0001;
            expect_out(0, pa, 0, t[0], 0, $sformatf("cond%0d", i)); tick(); idle();
            if (t[0]) begin
                pa = pa + 32'd8;
                expect_out(0, pa, 1, 0, 0, $sformatf("cond%0d_fl", i)); tick();
                pa = pa + 32'd4;
            end else begin
                pa = pa + 32'd4;
            end
        end

        tick();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the MIPS core, replacing the flat jump/branch select logic with a registered PC. It evaluates an encoded branch condition against the ALU `zero` and `neg` flags, and resolves register-jump, jump and branch requests in priority order. It generates pipeline flush bubbles, with an optional architectural delay slot. It sits between decode/ALU flag outputs and the instruction-memory address port.

## Interface
Parameters:
- `ADDR_W`, 32: PC width; legal range 28 to 32.
- `RESET_PC`, 0: PC value loaded on reset; must be word-aligned.
- `FLUSH_CYCLES`, 1: bubbles emitted after a taken redirect; legal range 1 to 4. Ignored when `DELAY_SLOT` = 1.
- `DELAY_SLOT`, 0: 1 = the instruction after a redirect executes and no flush is emitted.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  holds the PC and all state; requests are ignored and must be re-presented.
- `jr_valid_i`  in  1  register-jump request.
- `jr_addr_i`  in  ADDR_W  register-jump target.
- `jmp_valid_i`  in  1  absolute jump request.
- `jmp_index_i`  in  26  jump index field.
- `br_valid_i`  in  1  conditional branch request.
- `br_cond_i`  in  3  condition code.
- `br_offset_i`  in  16  signed word offset.
- `zero_i`, `neg_i`  in  1 each  ALU result flags.
- `pc_o`  out  ADDR_W  current fetch address (registered).
- `link_addr_o`  out  ADDR_W  return address: `pc_o`+4, or `pc_o`+8 when `DELAY_SLOT` = 1.
- `flush_o`  out  1  discard the instruction fetched this cycle.
- `redirect_o`  out  1  one-cycle pulse: a request was taken this cycle.
- `align_err_o`  out  1  one-cycle pulse: a taken `jr_addr_i` had bits [1:0] nonzero.

## Operation
- Condition codes:
  - 000 BEQ: `zero`.
  - 001 BNE: not `zero`.
  - 010 BLTZ: `neg`.
  - 011 BGEZ: not `neg`.
  - 100 BLEZ: `neg` or `zero`.
  - 101 BGTZ: neither `neg` nor `zero`.
  - 110 ALWAYS.
  - 111 NEVER.
- Priority when requests coincide: jr > jmp > branch. Lower-priority requests in the same cycle are dropped.
- Targets, with p4 = `pc_o`+4 and all arithmetic modulo 2^ADDR_W (wrap silently):
  - jr: `jr_addr_i` with bits [1:0] forced to 0; raises `align_err_o` if those bits were nonzero.
  - jmp: {p4[ADDR_W-1:28], `jmp_index_i`, 2'b00}. When ADDR_W = 28 the upper field is empty.
  - branch: p4 + (sign-extended `br_offset_i` << 2).
- "Taken" means jr_valid, or jmp_valid, or (br_valid and the condition is true), while not stalled and in a state that accepts requests.
- FSM states:
  - RUN: accepts requests. If none taken, `pc_o` <= p4. If taken and `DELAY_SLOT` = 0: `pc_o` <= target, go to FLUSH with counter = FLUSH_CYCLES. If taken and `DELAY_SLOT` = 1: `pc_o` <= p4, latch the target, go to SLOT.
  - FLUSH: `flush_o` = 1 and requests are ignored. Each non-stalled cycle `pc_o` <= p4 and the counter decrements. At counter = 1, return to RUN.
  - SLOT: requests are ignored (no branch in a delay slot). `pc_o` <= latched target, return to RUN.
- When stalled, `pc_o`, the state, the counter and the latched target are all held. `flush_o` holds its value. `redirect_o` and `align_err_o` are 0.
- Reset, asynchronous and possibly mid-FLUSH or mid-SLOT: `pc_o` = RESET_PC, state RUN, counter 0, latched target 0, `flush_o` = 0, `redirect_o` = 0, `align_err_o` = 0.

## Timing
- Request, flags and condition are sampled on edge t. The new `pc_o` is visible after edge t; latency is 1 cycle, or 2 with a delay slot.
- `redirect_o` and `align_err_o` are combinational in the request cycle, gated by state and stall.
- `flush_o` is registered. It is high for exactly FLUSH_CYCLES non-stalled cycles, starting the cycle after the redirect.
- `link_addr_o` is combinational from `pc_o`.

## Structure
- `pc_seq_pkg` holds:
  - condition-code localparams (COND_BEQ through COND_NEVER);
  - the state enum (ST_RUN, ST_FLUSH, ST_SLOT);
  - the width of the flush counter (3 bits).
- Sub-module `br_cond_eval`: combinational map of (`br_cond_i`, `zero_i`, `neg_i`) to a take bit. It is instantiated once and reused by future compare-branch variants.

## Test plan
- Reset/sequential run: release `rst_n` with RESET_PC = 0x400. `pc_o` = 0x400, 0x404, 0x408; `flush_o` = 0 throughout.
- BEQ forward with default parameters: at `pc_o` = 0x100 apply `br_cond_i` = 000, `zero_i` = 1, `br_offset_i` = 0x0003. Next `pc_o` = 0x110, `flush_o` = 1 for one cycle, then 0x114.
- Priority: at `pc_o` = 0x200 assert jr (0x8000), jmp and a taken branch together. Next `pc_o` = 0x8000; one `redirect_o` pulse.
- Delay slot: `DELAY_SLOT` = 1, at `pc_o` = 0x40 take jmp with index 0x100. `pc_o` = 0x44, then 0x400; `flush_o` stays 0. Requests at 0x44 are ignored.
- Stall and reset: FLUSH_CYCLES = 3; take a branch, then stall 2 cycles mid-flush. Flush stays high for 3 non-stalled cycles. Pulse `rst_n` low mid-FLUSH: immediately `pc_o` = RESET_PC and `flush_o` = 0.
- Wrap and misalignment:
  - at `pc_o` = 0xFFFFFFFC take ALWAYS with offset 0: next `pc_o` = 0x00000000;
  - jr to 0x1003: `pc_o` = 0x1000, `align_err_o` pulses once.
